// File: rtl/gnr_attractor_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gnr_attractor_ctrl_if: node-control bus and result handshake of the          |
// | attractor sequencer. Option GNR_CTRL_STEPCOUNT_EN adds res_steps. Rev 1.0    |
// +----------------------------------------------------------------------------+
interface gnr_attractor_ctrl_if #(
   parameter int N_NODES   = 8,
   parameter int MAX_STEPS = 1024
);
   localparam int CW = $clog2(MAX_STEPS + 1);

   logic               reset_nos;
   logic [N_NODES-1:0] init_vec;
   logic               start_s0;
   logic               start_s1;
   logic [N_NODES-1:0] s0_vec;
   logic [N_NODES-1:0] s1_vec;
   logic               res_valid;
   logic               res_ready;
   logic [N_NODES-1:0] res_init;
   logic [N_NODES-1:0] res_state;
   logic [CW-1:0]      res_period;
   logic               res_timeout;
`ifdef GNR_CTRL_STEPCOUNT_EN
   logic [CW-1:0]      res_steps;

   modport master (
      output reset_nos, init_vec, start_s0, start_s1,
      input  s0_vec, s1_vec,
      output res_valid, res_init, res_state, res_period, res_timeout, res_steps,
      input  res_ready
   );
   modport slave (
      input  reset_nos, init_vec, start_s0, start_s1,
      output s0_vec, s1_vec,
      input  res_valid, res_init, res_state, res_period, res_timeout, res_steps,
      output res_ready
   );
`else
   modport master (
      output reset_nos, init_vec, start_s0, start_s1,
      input  s0_vec, s1_vec,
      output res_valid, res_init, res_state, res_period, res_timeout,
      input  res_ready
   );
   modport slave (
      input  reset_nos, init_vec, start_s0, start_s1,
      output s0_vec, s1_vec,
      input  res_valid, res_init, res_state, res_period, res_timeout,
      output res_ready
   );
`endif
endinterface
`default_nettype wire

// File: rtl/gnr_attractor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gnr_attractor_ctrl: sweeps initial states, finds each attractor by           |
// | tortoise/hare stepping and reports its period. Option macro:                 |
// | GNR_CTRL_STEPCOUNT_EN (adds res_steps). Rev 1.0                              |
// +----------------------------------------------------------------------------+
module gnr_attractor_ctrl #(
   parameter int N_NODES   = 8,
   parameter int MAX_STEPS = 1024
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               start,
   input  wire logic [N_NODES-1:0] init_first,
   input  wire logic [N_NODES-1:0] init_last,
   output logic                    busy,
   output logic                    done,
   gnr_attractor_ctrl_if.master    bus
);
   localparam int            CW    = $clog2(MAX_STEPS + 1);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_STEPS);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_TWO = CW'(2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_FIND   = 3'd2,
      S_CYCLE  = 3'd3,
      S_REPORT = 3'd4,
      S_NEXT   = 3'd5
   } state_t;

   state_t             r_state;
   logic [N_NODES-1:0] r_cur;
   logic [N_NODES-1:0] r_last;
   logic [N_NODES-1:0] r_cap_state;
   logic [CW-1:0]      r_j;
   logic [CW-1:0]      r_p;
   logic               r_reset_nos;
   logic               r_done;
   logic               r_res_valid;
   logic [N_NODES-1:0] r_res_init;
   logic [N_NODES-1:0] r_res_state;
   logic [CW-1:0]      r_res_period;
   logic               r_res_timeout;
`ifdef GNR_CTRL_STEPCOUNT_EN
   logic [CW-1:0]      r_res_steps;
`endif

   logic               w_eq;
   logic               w_hit_f;
   logic               w_hit_c;
   logic               w_rep_en;
   logic [N_NODES-1:0] w_rep_state;
   logic [CW-1:0]      w_rep_period;
   logic               w_rep_to;

   assign w_eq    = (bus.s0_vec == bus.s1_vec);
   assign w_hit_f = (r_state == S_FIND) && !r_j[0] && (r_j >= C_TWO) && w_eq;
   assign w_hit_c = (r_state == S_CYCLE) && (r_p != '0) && w_eq;

   // Both exits into REPORT funnel through one set of capture values.
   always_comb begin
      w_rep_en     = 1'b0;
      w_rep_state  = r_cap_state;
      w_rep_period = '0;
      w_rep_to     = 1'b0;
      if ((r_state == S_FIND) && !w_hit_f && (r_j == C_MAX)) begin
         w_rep_en    = 1'b1;
         w_rep_state = bus.s0_vec;
         w_rep_to    = 1'b1;
      end else if (r_state == S_CYCLE) begin
         if (w_hit_c) begin
            w_rep_en     = 1'b1;
            w_rep_period = r_p;
         end else if (r_p == C_MAX) begin
            w_rep_en = 1'b1;
            w_rep_to = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cur         <= '0;
         r_last        <= '0;
         r_cap_state   <= '0;
         r_j           <= '0;
         r_p           <= '0;
         r_reset_nos   <= 1'b0;
         r_done        <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_init    <= '0;
         r_res_state   <= '0;
         r_res_period  <= '0;
         r_res_timeout <= 1'b0;
`ifdef GNR_CTRL_STEPCOUNT_EN
         r_res_steps   <= '0;
`endif
      end else begin
         r_reset_nos <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur       <= init_first;
                  r_last      <= init_last;
                  r_reset_nos <= 1'b1;
                  r_state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_j     <= '0;
               r_state <= S_FIND;
            end
            S_FIND: begin
               if (w_hit_f) begin
                  r_cap_state <= bus.s0_vec;
                  r_p         <= '0;
                  r_state     <= S_CYCLE;
               end else if (!w_rep_en) begin
                  r_j <= r_j + C_ONE;
               end
            end
            S_CYCLE: begin
               if (!w_rep_en) begin
                  r_p <= r_p + C_ONE;
               end
            end
            S_REPORT: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= S_NEXT;
               end
            end
            S_NEXT: begin
               // Compare before incrementing so an all-ones last state never wraps.
               if (r_cur == r_last) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cur       <= r_cur + 1'b1;
                  r_reset_nos <= 1'b1;
                  r_state     <= S_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_rep_en) begin
            r_state       <= S_REPORT;
            r_res_valid   <= 1'b1;
            r_res_init    <= r_cur;
            r_res_state   <= w_rep_state;
            r_res_period  <= w_rep_period;
            r_res_timeout <= w_rep_to;
`ifdef GNR_CTRL_STEPCOUNT_EN
            r_res_steps   <= r_j;
`endif
         end
      end
   end

   assign busy            = (r_state != S_IDLE);
   assign done            = r_done;
   assign bus.reset_nos   = r_reset_nos;
   assign bus.init_vec    = (r_state == S_IDLE) ? '0 : r_cur;
   assign bus.start_s0    = (r_state == S_FIND) && !w_hit_f;
   assign bus.start_s1    = ((r_state == S_FIND) && !w_hit_f) || ((r_state == S_CYCLE) && !w_hit_c);
   assign bus.res_valid   = r_res_valid;
   assign bus.res_init    = r_res_init;
   assign bus.res_state   = r_res_state;
   assign bus.res_period  = r_res_period;
   assign bus.res_timeout = r_res_timeout;
`ifdef GNR_CTRL_STEPCOUNT_EN
   assign bus.res_steps   = r_res_steps;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gnr_attractor_ctrl.sv
`default_nettype none
// Bench for gnr_attractor_ctrl: node-bank environment plus a trajectory-based result model.
module tb_gnr_attractor_ctrl;
   localparam int N  = 3;
   localparam int MA = 1024;
   localparam int MB = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start_a, start_b;
   logic [N-1:0] first_a, last_a, first_b, last_b;
   logic         busy_a, done_a, busy_b, done_b;

   gnr_attractor_ctrl_if #(.N_NODES(N), .MAX_STEPS(MA)) bus_a();
   gnr_attractor_ctrl_if #(.N_NODES(N), .MAX_STEPS(MB)) bus_b();

   gnr_attractor_ctrl #(.N_NODES(N), .MAX_STEPS(MA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .init_first(first_a), .init_last(last_a),
      .busy(busy_a), .done(done_a), .bus(bus_a));
   gnr_attractor_ctrl #(.N_NODES(N), .MAX_STEPS(MB)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .init_first(first_b), .init_last(last_b),
      .busy(busy_b), .done(done_b), .bus(bus_b));

   int net_sel;
   int lut [8];

   function automatic int fnet(int x);
      case (net_sel)
         0:       fnet = x & 7;
         1:       fnet = ~x & 7;
         2:       fnet = (x + 1) & 7;
         default: fnet = lut[x & 7];
      endcase
   endfunction

   // Node banks: load on reset_nos, s1 steps every strobe, s0 every other strobe.
   logic ph_a, ph_b;
   always @(posedge clk) begin
      if (bus_a.reset_nos) begin
         bus_a.s0_vec <= bus_a.init_vec;
         bus_a.s1_vec <= bus_a.init_vec;
         ph_a         <= 1'b0;
      end else begin
         if (bus_a.start_s1) bus_a.s1_vec <= N'(fnet(int'(bus_a.s1_vec)));
         if (bus_a.start_s0) begin
            if (!ph_a) bus_a.s0_vec <= N'(fnet(int'(bus_a.s0_vec)));
            ph_a <= ~ph_a;
         end
      end
   end
   always @(posedge clk) begin
      if (bus_b.reset_nos) begin
         bus_b.s0_vec <= bus_b.init_vec;
         bus_b.s1_vec <= bus_b.init_vec;
         ph_b         <= 1'b0;
      end else begin
         if (bus_b.start_s1) bus_b.s1_vec <= N'(fnet(int'(bus_b.s1_vec)));
         if (bus_b.start_s0) begin
            if (!ph_b) bus_b.s0_vec <= N'(fnet(int'(bus_b.s0_vec)));
            ph_b <= ~ph_b;
         end
      end
   end

   typedef struct {
      int init; int state; int period; int tmo; int steps; int lat; int s1cnt; bit last;
   } exp_t;

   // Result from the explicit trajectory x, f(x), f^2(x), ...
   function automatic exp_t model(int x, int m);
      exp_t e;
      int   traj[];
      int   y, z, p;
      bit   hit;
      traj = new[m + 1];
      traj[0] = x;
      for (int k = 1; k <= m; k++) traj[k] = fnet(traj[k-1]);
      e.init = x; e.tmo = 0; e.period = 0; e.steps = m; e.last = 1'b0;
      hit = 1'b0;
      for (int k = 2; k <= m && !hit; k += 2)
         if (traj[k] == traj[k/2]) begin hit = 1'b1; e.steps = k; end
      if (!hit) begin
         e.tmo = 1; e.state = traj[(m + 1) / 2]; e.lat = m + 2; e.s1cnt = m + 1;
      end else begin
         y = traj[e.steps / 2];
         e.state = y;
         z = y; p = 0;
         for (int q = 1; q <= m && p == 0; q++) begin
            z = fnet(z);
            if (z == y) p = q;
         end
         if (p != 0) begin
            e.period = p; e.lat = e.steps + p + 3; e.s1cnt = e.steps + p;
         end else begin
            e.tmo = 1; e.lat = e.steps + m + 3; e.s1cnt = e.steps + m + 1;
         end
      end
      return e;
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   exp_t q_a[$];
   int   since_acc = -1;
   int   lat_a = 0;
   int   s1c_a = 0;
   bit   lat_pend = 1'b0;

   // Per-cycle comparison of dut_a against the model queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            since_acc = -1;
            lat_pend  = 1'b0;
         end else begin
            if (since_acc >= 0) since_acc++;
            check("done_pulse", int'(done_a), int'(since_acc == 2));
            if (since_acc == 2) check("busy_after_done", int'(busy_a), 0);
            if (bus_a.reset_nos) begin
               lat_a = 0; s1c_a = 0; lat_pend = 1'b1;
            end else begin
               lat_a++;
               if (bus_a.start_s1) s1c_a++;
            end
            if (bus_a.res_valid) begin
               check("strobes_in_report",
                     int'(bus_a.reset_nos | bus_a.start_s0 | bus_a.start_s1), 0);
               check("busy_in_report", int'(busy_a), 1);
               if (q_a.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = q_a[0];
                  check("res_init", int'(bus_a.res_init), e.init);
                  check("res_state", int'(bus_a.res_state), e.state);
                  check("res_period", int'(bus_a.res_period), e.period);
                  check("res_timeout", int'(bus_a.res_timeout), e.tmo);
`ifdef GNR_CTRL_STEPCOUNT_EN
                  check("res_steps", int'(bus_a.res_steps), e.steps);
`endif
                  if (lat_pend) begin
                     check("latency", lat_a, e.lat);
                     check("s1_strobes", s1c_a, e.s1cnt);
                     lat_pend = 1'b0;
                  end
                  if (bus_a.res_ready) begin
                     void'(q_a.pop_front());
                     if (e.last) since_acc = 0;
                  end
               end
            end
         end
      end
   end

   int bp_hold;

   task automatic run_sweep(input int f, input int l, input int mode);
      exp_t e;
      int   guard;
      for (int x = f; x <= l; x++) begin
         e = model(x, MA);
         e.last = (x == l);
         q_a.push_back(e);
      end
      @(posedge clk); #1;
      first_a = N'(f); last_a = N'(l); start_a = 1'b1;
      bus_a.res_ready = (mode == 0);
      @(posedge clk); #1;
      start_a = 1'b0;
      bp_hold = 0;
      guard   = 0;
      while (!done_a && guard < 20000) begin
         case (mode)
            0:       bus_a.res_ready = 1'b1;
            1:       bus_a.res_ready = ($urandom_range(0, 3) != 0);
            default: bus_a.res_ready = (bp_hold >= 5);
         endcase
         @(negedge clk);
         if (bus_a.res_valid && !bus_a.res_ready) bp_hold++;
         @(posedge clk); #1;
         guard++;
      end
      check("sweep_finished", int'(guard < 20000), 1);
      check("queue_drained", q_a.size(), 0);
      if (mode == 2) check("bp_hold_cycles", bp_hold, 5);
      bus_a.res_ready = 1'b1;
   endtask

   initial begin
      exp_t e;
      int   guard, find_cyc, lo, hi;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      first_a = '0; last_a = '0; first_b = '0; last_b = '0;
      bus_a.res_ready = 1'b1; bus_b.res_ready = 1'b1;
      net_sel = 0;
      for (int i = 0; i < 8; i++) lut[i] = i;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_valid", int'(bus_a.res_valid), 0);
      check("rst_strobes", int'(bus_a.reset_nos | bus_a.start_s0 | bus_a.start_s1), 0);
      check("rst_init_vec", int'(bus_a.init_vec), 0);
      check("rst_res_init", int'(bus_a.res_init), 0);
      check("rst_res_state", int'(bus_a.res_state), 0);
      check("rst_res_period", int'(bus_a.res_period), 0);
      check("rst_res_timeout", int'(bus_a.res_timeout), 0);
      check("rst_b_busy", int'(busy_b), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Model pins from hand-worked trajectories.
      net_sel = 0; e = model(5, MA);
      check("pin_fix_steps", e.steps, 2);
      check("pin_fix_period", e.period, 1);
      check("pin_fix_lat", e.lat, 6);
      run_sweep(5, 5, 0);

      net_sel = 1; e = model(1, MA);
      check("pin_tog_steps", e.steps, 4);
      check("pin_tog_state", e.state, 1);
      check("pin_tog_period", e.period, 2);
      run_sweep(1, 1, 0);

      net_sel = 2; e = model(1, MA);
      check("pin_cnt_steps", e.steps, 16);
      check("pin_cnt_state", e.state, 1);
      check("pin_cnt_period", e.period, 8);
      run_sweep(0, 2, 0);

      net_sel = 2;
      run_sweep(4, 5, 2);

      for (int t = 0; t < 12; t++) begin
         net_sel = 3;
         for (int i = 0; i < 8; i++) lut[i] = $urandom_range(0, 7);
         lo = $urandom_range(0, 7);
         hi = $urandom_range(lo, 7);
         if (hi - lo > 3) hi = lo + 3;
         if (t == 11) begin lo = 6; hi = 7; end
         run_sweep(lo, hi, 1);
      end

      // Reset while the sequencer is measuring a period.
      net_sel = 2;
      for (int x = 0; x <= 7; x++) begin
         e = model(x, MA); e.last = (x == 7); q_a.push_back(e);
      end
      @(posedge clk); #1;
      first_a = 3'd0; last_a = 3'd7; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(bus_a.start_s1 && !bus_a.start_s0 && busy_a) && guard < 500);
      check("reached_cycle", int'(guard < 500), 1);
      rst = 1'b1;
      q_a.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", int'(busy_a), 0);
      check("midrst_valid", int'(bus_a.res_valid), 0);
      check("midrst_strobes", int'(bus_a.reset_nos | bus_a.start_s0 | bus_a.start_s1), 0);
      run_sweep(3, 3, 0);

      // Timeout on the small-limit instance.
      net_sel = 2; e = model(0, MB);
      check("pin_tmo_flag", e.tmo, 1);
      check("pin_tmo_state", e.state, 5);
      @(posedge clk); #1;
      first_b = 3'd0; last_b = 3'd0; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      guard = 0; find_cyc = 0;
      while (guard < 200) begin
         @(negedge clk);
         if (bus_b.res_valid) break;
         if (bus_b.start_s0 && bus_b.start_s1) find_cyc++;
         guard++;
      end
      check("b_result_seen", int'(bus_b.res_valid), 1);
      check("b_find_cycles", find_cyc, 11);
      check("b_timeout", int'(bus_b.res_timeout), 1);
      check("b_period", int'(bus_b.res_period), 0);
      check("b_init", int'(bus_b.res_init), 0);
      check("b_state", int'(bus_b.res_state), e.state);
`ifdef GNR_CTRL_STEPCOUNT_EN
      check("b_steps", int'(bus_b.res_steps), 10);
`endif
      guard = 0;
      while (!done_b && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("b_done", int'(done_b), 1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
